// File: rtl/busca_instrucao.sv
// Instruction fetch stage: presents the PC index to a synchronous ROM, tags the
// returned word with its address, buffers it in a small FIFO and hands it to
// decode over valid/ready. Because the PC never stalls, this block steers the
// PC through Selecao/IndiceAux to replay dropped fetches and to follow branches.
module busca_instrucao #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] Indice,
    output logic                  Selecao,
    output logic [ADDR_WIDTH-1:0] IndiceAux,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  desvio,
    input  logic [ADDR_WIDTH-1:0] desvio_alvo,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Outstanding ROM request: the index whose data arrives this cycle
    logic                  req_v;
    logic [ADDR_WIDTH-1:0] req_pc;

    // FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] fifo_data [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pc   [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;

    logic pop_c;
    logic full_c;
    logic ovf_c;
    logic push_c;

    assign mem_addr = Indice;

    // Head presentation straight from FIFO registers; zeroed when empty
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? fifo_data[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : '0;

    // Per-edge decisions: branch flush beats overflow replay beats push
    always_comb begin
        pop_c  = instr_valid && instr_ready;
        full_c = (count == CNT_W'(DEPTH));
        ovf_c  = req_v && full_c && !pop_c && !desvio;
        push_c = req_v && !desvio && !ovf_c;
    end

    // Request capture and PC redirect control
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_v     <= 1'b0;
            req_pc    <= '0;
            Selecao   <= 1'b0;
            IndiceAux <= '0;
        end else begin
            req_pc <= Indice;
            // Index shown while a redirect is pending or being applied is wrong-path
            req_v  <= !(desvio || ovf_c || Selecao);
            if (desvio) begin
                Selecao   <= 1'b1;
                IndiceAux <= desvio_alvo;
            end else if (ovf_c) begin
                Selecao   <= 1'b1;
                IndiceAux <= req_pc;
            end else begin
                Selecao   <= 1'b0;
            end
        end
    end

    // FIFO pointers and occupancy; a branch empties the queue
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (desvio) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    // FIFO payload write; contents are don't-care while unoccupied
    always_ff @(posedge clock) begin
        if (push_c) begin
            fifo_data[wr_ptr] <= mem_data;
            fifo_pc[wr_ptr]   <= req_pc;
        end
    end

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao with a PC model and a ROM returning
// 0xA0000000 + address.
module tb_busca_instrucao;

    logic        clock;
    logic        reset_n;
    logic [9:0]  Indice;
    logic        Selecao;
    logic [9:0]  IndiceAux;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data;
    logic        desvio;
    logic [9:0]  desvio_alvo;
    logic [31:0] instr;
    logic [9:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    int checks;
    int failures;

    busca_instrucao #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .Indice      (Indice),
        .Selecao     (Selecao),
        .IndiceAux   (IndiceAux),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .desvio      (desvio),
        .desvio_alvo (desvio_alvo),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // PC model: loads IndiceAux when Selecao, otherwise increments
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)     Indice <= 10'd0;
        else if (Selecao) Indice <= IndiceAux;
        else              Indice <= Indice + 10'd1;
    end

    // Synchronous ROM model
    always @(posedge clock) begin
        mem_data <= 32'hA000_0000 + 32'(mem_addr);
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // Pulse reset for one cycle starting at the current negedge
    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset_n     = 1'b0;
        desvio      = 1'b0;
        desvio_alvo = 10'd0;
        instr_ready = 1'b1;
        #2;
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc",    32'(instr_pc), 32'd0);
        check("rst_sel",   32'(Selecao), 32'd0);
        check("rst_aux",   32'(IndiceAux), 32'd0);

        // 1: free-running stream
        @(negedge clock);
        reset_n = 1'b1;
        step();
        check("t1_valid_e1", 32'(instr_valid), 32'd0);
        step();
        check("t1_valid_e2", 32'(instr_valid), 32'd1);
        check("t1_pc0",      32'(instr_pc), 32'd0);
        check("t1_instr0",   instr, 32'hA000_0000);
        for (int k = 1; k <= 6; k++) begin
            step();
            check("t1_valid", 32'(instr_valid), 32'd1);
            check("t1_pc",    32'(instr_pc), 32'(k));
            check("t1_instr", instr, 32'hA000_0000 + 32'(k));
            check("t1_sel",   32'(Selecao), 32'd0);
        end

        // 2: stall until full, overflow replay, then drain in order
        instr_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 5; k++) step();
        check("t2_full_valid", 32'(instr_valid), 32'd1);
        check("t2_full_pc",    32'(instr_pc), 32'd0);
        check("t2_sel_e5",     32'(Selecao), 32'd0);
        step();
        check("t2_sel_e6", 32'(Selecao), 32'd1);
        check("t2_aux_e6", 32'(IndiceAux), 32'd4);
        step();
        check("t2_sel_e7", 32'(Selecao), 32'd0);
        step();
        check("t2_sel_e8", 32'(Selecao), 32'd0);
        step();
        check("t2_sel_e9", 32'(Selecao), 32'd1);
        check("t2_aux_e9", 32'(IndiceAux), 32'd4);
        instr_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("t2_drain_valid", 32'(instr_valid), 32'd1);
            check("t2_drain_pc",    32'(instr_pc), 32'(k));
            check("t2_drain_instr", instr, 32'hA000_0000 + 32'(k));
            step();
        end

        // 3: branch with three entries queued, no pop
        instr_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 4; k++) step();
        check("t3_pre_valid", 32'(instr_valid), 32'd1);
        check("t3_pre_pc",    32'(instr_pc), 32'd0);
        desvio      = 1'b1;
        desvio_alvo = 10'h3F0;
        step();
        desvio = 1'b0;
        check("t3_flush_valid", 32'(instr_valid), 32'd0);
        check("t3_flush_instr", instr, 32'd0);
        check("t3_flush_pc",    32'(instr_pc), 32'd0);
        check("t3_sel",         32'(Selecao), 32'd1);
        check("t3_aux",         32'(IndiceAux), 32'h3F0);
        instr_ready = 1'b1;
        step();
        check("t3_sel_off",  32'(Selecao), 32'd0);
        check("t3_valid_e1", 32'(instr_valid), 32'd0);
        step();
        check("t3_valid_e2", 32'(instr_valid), 32'd0);
        step();
        check("t3_valid_e3", 32'(instr_valid), 32'd1);
        check("t3_pc_e3",    32'(instr_pc), 32'h3F0);
        check("t3_instr_e3", instr, 32'hA000_03F0);
        step();
        check("t3_pc_e4", 32'(instr_pc), 32'h3F1);
        step();
        check("t3_pc_e5", 32'(instr_pc), 32'h3F2);

        // 4: branch on the same edge that pops pc 7
        do_reset();
        for (int k = 0; k < 9; k++) step();
        check("t4_head7", 32'(instr_pc), 32'd7);
        desvio      = 1'b1;
        desvio_alvo = 10'h055;
        step();
        desvio = 1'b0;
        check("t4_valid_e0", 32'(instr_valid), 32'd0);
        check("t4_sel",      32'(Selecao), 32'd1);
        check("t4_aux",      32'(IndiceAux), 32'h055);
        step();
        check("t4_valid_e1", 32'(instr_valid), 32'd0);
        step();
        check("t4_valid_e2", 32'(instr_valid), 32'd0);
        step();
        check("t4_valid_e3", 32'(instr_valid), 32'd1);
        check("t4_pc_e3",    32'(instr_pc), 32'h055);
        step();
        check("t4_pc_e4", 32'(instr_pc), 32'h056);

        // 5: back-to-back branches, latest target wins
        desvio      = 1'b1;
        desvio_alvo = 10'h100;
        step();
        check("t5_sel_a", 32'(Selecao), 32'd1);
        check("t5_aux_a", 32'(IndiceAux), 32'h100);
        desvio_alvo = 10'h200;
        step();
        desvio = 1'b0;
        check("t5_sel_b", 32'(Selecao), 32'd1);
        check("t5_aux_b", 32'(IndiceAux), 32'h200);
        step();
        check("t5_sel_off",  32'(Selecao), 32'd0);
        check("t5_aux_hold", 32'(IndiceAux), 32'h200);
        check("t5_valid_e1", 32'(instr_valid), 32'd0);
        step();
        check("t5_valid_e2", 32'(instr_valid), 32'd0);
        step();
        check("t5_valid_e3", 32'(instr_valid), 32'd1);
        check("t5_pc_e3",    32'(instr_pc), 32'h200);
        step();
        check("t5_pc_e4", 32'(instr_pc), 32'h201);
        step();
        step();
        check("t6_pre_pc", 32'(instr_pc), 32'h203);

        // 6: asynchronous reset between edges
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_valid", 32'(instr_valid), 32'd0);
        check("t6_instr", instr, 32'd0);
        check("t6_pc",    32'(instr_pc), 32'd0);
        check("t6_sel",   32'(Selecao), 32'd0);
        check("t6_aux",   32'(IndiceAux), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        step();
        check("t6_restart_e1", 32'(instr_valid), 32'd0);
        step();
        check("t6_restart_pc0", 32'(instr_pc), 32'd0);
        step();
        check("t6_restart_pc1", 32'(instr_pc), 32'd1);
        step();
        check("t6_restart_pc2", 32'(instr_pc), 32'd2);
        desvio      = 1'b1;
        desvio_alvo = 10'h02A;
        @(posedge clock);
        #2;
        desvio = 1'b0;
        check("t6b_sel_pre", 32'(Selecao), 32'd1);
        check("t6b_aux_pre", 32'(IndiceAux), 32'h02A);
        reset_n = 1'b0;
        #1;
        check("t6b_sel", 32'(Selecao), 32'd0);
        check("t6b_aux", 32'(IndiceAux), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/busca_instrucao.md
Name: busca_instrucao

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Each cycle it presents the PC index to the synchronous instruction ROM and tags the returned word with its address.
- Fetched words are buffered in a small FIFO and handed to decode over a valid/ready handshake.
- The PC cannot stall, so this block drives the PC's Selecao/IndiceAux inputs. It uses them to replay fetches dropped on overflow and to redirect on taken branches/jumps.

Parameters:
ADDR_WIDTH, 10, instruction index width (matches PC Indice)
DATA_WIDTH, 32, instruction word width
DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
Indice  in  ADDR_WIDTH  current PC index
Selecao  out  1  PC load select (registered, 1-cycle pulse per redirect)
IndiceAux  out  ADDR_WIDTH  PC load target (registered)
mem_addr  out  ADDR_WIDTH  ROM address, combinationally equal to Indice
mem_data  in  DATA_WIDTH  ROM read data, valid the cycle after mem_addr is presented
desvio  in  1  taken branch/jump from execute (flush + redirect)
desvio_alvo  in  ADDR_WIDTH  branch/jump target
instr  out  DATA_WIDTH  head instruction; 0 when FIFO empty
instr_pc  out  ADDR_WIDTH  head instruction index; 0 when FIFO empty
instr_valid  out  1  FIFO non-empty
instr_ready  in  1  decode accepts head

Behaviour:
- Reset (reset_n=0, takes effect without a clock edge):
  - FIFO empty; instr_valid=0, instr=0, instr_pc=0.
  - Selecao=0, IndiceAux=0, req_v=0, req_pc=0.
- Request register: at each edge, req_v and req_pc capture whether the current Indice is a real fetch.
  - req_pc <= Indice.
  - req_v <= !(desvio || ovf || Selecao).
  - Effect: the index presented while a redirect is being decided, and the index presented while Selecao=1, are both wrong-path and never captured.
- Candidate: when req_v=1, the pair {mem_data, req_pc} is a push candidate this cycle.
- Pop: happens at an edge when instr_valid && instr_ready.
- Per-edge priority:
  1. desvio=1:
     - Pop still happens if the handshake holds (decode took the head).
     - All remaining entries are cleared and the candidate is discarded.
     - Selecao<=1, IndiceAux<=desvio_alvo.
  2. Otherwise ovf = candidate && count==DEPTH && !pop:
     - Candidate is discarded.
     - Selecao<=1, IndiceAux<=req_pc (replay).
  3. Otherwise:
     - The candidate, if any, is pushed; simultaneous push and pop is allowed, including when full.
     - Selecao<=0.
- Selecao pulses are one cycle each; back-to-back redirects hold it high and the latest target wins.
- Latency:
  - Indice presented in cycle n is visible at the FIFO head after edge n+2 (if the FIFO was empty).
  - Steady-state throughput is 1 instruction/cycle.
- Redirect penalty: desvio sampled at edge E gives Selecao=1 during (E,E+1]. The PC loads at E+1, req captures the target at E+2, and the target is at the head after E+3.
- Ordering: instr_pc values leaving the FIFO always follow the program sequence. No address is duplicated or skipped across overflow replays. No wrong-path index is ever emitted after a desvio.
- Count logic: ptr/count arithmetic wraps mod DEPTH; count spans 0..DEPTH.
- Outputs instr/instr_pc/instr_valid come from FIFO registers only (no combinational path from mem_data).

Test Plan:
- Bench environment: a PC model honoring Selecao/IndiceAux and a ROM model returning 0xA0000000+addr.
1. Reset release, instr_ready=1 -> instr_valid rises after edge 2; stream instr_pc=0,1,2,... with instr=0xA0000000,0xA0000001,...; Selecao never asserts.
2. instr_ready=0 from reset, DEPTH=4 -> FIFO holds pc 0..3. Next candidate pc=4 gives a 1-cycle Selecao with IndiceAux=4, repeated while stalled. After instr_ready=1 -> output 0,1,2,3,4,5 with no gap or duplicate.
3. FIFO holding 3 entries, desvio=1 with desvio_alvo=0x3F0 (no pop) -> instr_valid=0 after the edge, Selecao=1 with IndiceAux=0x3F0 for one cycle, first valid instr_pc=0x3F0 three edges after the desvio edge, then 0x3F1,...
4. desvio=1 on the same edge as a pop of head pc=7 -> pc 7 counted as consumed, entries 8+ discarded, next output is desvio_alvo.
5. desvio on two consecutive edges (alvo 0x100 then 0x200) -> Selecao high for 2 cycles, IndiceAux ends at 0x200, no 0x100-path instruction ever emitted.
6. reset_n driven low mid-stream between edges -> instr_valid, Selecao, instr and instr_pc go to 0 immediately; stream restarts correctly after release.
